// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: op encodings, EPC register address and the
// in-flight write slot layout used by the hazard tracker.
package cp0_pkg;

  localparam logic [2:0] CP0OP_MFC0 = 3'b001;
  localparam logic [2:0] CP0OP_MTC0 = 3'b010;
  localparam logic [2:0] CP0OP_ERET = 3'b100;

  localparam int CP0_EPC_CS  = 14;
  localparam int CP0_EPC_SEL = 0;

  localparam int CP0_CS_W   = 5;
  localparam int CP0_SEL_W  = 3;
  localparam int CP0_DATA_W = 32;

  // Slot layout at the architectural widths; the tracker mirrors it at its own widths.
  typedef struct packed {
    logic                  valid;
    logic [CP0_CS_W-1:0]   cs;
    logic [CP0_SEL_W-1:0]  sel;
    logic [CP0_DATA_W-1:0] data;
  } cp0_slot_t;

  function automatic logic cp0_is_read(input logic [2:0] op);
    return (op == CP0OP_MFC0) || (op == CP0OP_ERET);
  endfunction

endpackage

// File: rtl/cp0_prio_match.sv
// Youngest-first priority encoder: the lowest-indexed set match bit wins.
module cp0_prio_match #(
  parameter  int DEPTH = 3,
  localparam int IDX_W = $clog2(DEPTH) + 1
) (
  input  logic [DEPTH-1:0] match,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_fwd_tracker.sv
// CP0 hazard tracker: shift-register scoreboard of in-flight mtc0 writes,
// forwarding to mfc0/eret in ID, stalling on unready data, and committing at the tail.
module cp0_fwd_tracker
  import cp0_pkg::*;
#(
  parameter int DEPTH       = 3,
  parameter int READY_STAGE = 0,
  parameter int DATA_W      = 32,
  parameter int CS_W        = 5,
  parameter int SEL_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [2:0]             id_cp0op,
  input  logic [CS_W-1:0]        id_cs,
  input  logic [SEL_W-1:0]       id_sel,
  input  logic [DATA_W-1:0]      id_wdata,
  output logic                   fwd_hit,
  output logic [$clog2(DEPTH):0] fwd_slot,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   stall,
  output logic                   cp0_we,
  output logic [CS_W-1:0]        cp0_cs,
  output logic [SEL_W-1:0]       cp0_sel,
  output logic [DATA_W-1:0]      cp0_wdata
);

  localparam int SLOT_W = $clog2(DEPTH) + 1;
  // Slots below READY_STAGE hold data that is not yet usable by ID.
  localparam logic [DEPTH-1:0] EARLY_MASK = DEPTH'((64'd1 << READY_STAGE) - 64'd1);

  typedef struct packed {
    logic              valid;
    logic [CS_W-1:0]   cs;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t              slot_w   [DEPTH];
  slot_t              shift_in [DEPTH];
  slot_t              ins_slot;
  logic               rd_en;
  logic [CS_W-1:0]    key_cs;
  logic [SEL_W-1:0]   key_sel;
  logic [DEPTH-1:0]   match;
  logic               win_hit;
  logic [SLOT_W-1:0]  win_idx;

  always_comb begin
    rd_en   = id_valid && cp0_is_read(id_cp0op);
    key_cs  = id_cs;
    key_sel = id_sel;
    if (id_cp0op == CP0OP_ERET) begin
      key_cs  = CS_W'(CP0_EPC_CS);
      key_sel = SEL_W'(CP0_EPC_SEL);
    end
  end

  cp0_prio_match #(.DEPTH(DEPTH)) u_prio (
    .match (match),
    .hit   (win_hit),
    .idx   (win_idx)
  );

  // The youngest match sits below READY_STAGE exactly when any early slot matches.
  always_comb begin
    stall    = |(match & EARLY_MASK);
    fwd_hit  = win_hit && !stall;
    fwd_slot = fwd_hit ? win_idx + SLOT_W'(1) : '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_hit && (win_idx == SLOT_W'(i))) fwd_data = slot_w[i].data;
    end
  end

  always_comb begin
    ins_slot.valid = id_valid && (id_cp0op == CP0OP_MTC0) && !stall;
    ins_slot.cs    = id_cs;
    ins_slot.sel   = id_sel;
    ins_slot.data  = id_wdata;
  end

  genvar g;
  for (g = 0; g < DEPTH; g++) begin : g_slot
    localparam bit LAST = (g == DEPTH - 1);
    slot_t slot_q;
    slot_t slot_d;

    if (g == 0) begin : g_src
      assign shift_in[g] = ins_slot;
    end else begin : g_src
      assign shift_in[g] = slot_w[g-1];
    end

    assign slot_w[g] = slot_q;
    assign match[g]  = rd_en && slot_q.valid && (slot_q.cs == key_cs) && (slot_q.sel == key_sel);

    // The tail slot is past the commit point, so a held flush leaves it alone.
    always_comb begin
      slot_d = slot_q;
      if (advance) begin
        slot_d = shift_in[g];
        if (flush) slot_d.valid = 1'b0;
      end else if (flush && !LAST) begin
        slot_d.valid = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) slot_q.valid <= 1'b0;
      else     slot_q.valid <= slot_d.valid;
      slot_q.cs   <= slot_d.cs;
      slot_q.sel  <= slot_d.sel;
      slot_q.data <= slot_d.data;
    end
  end

  always_comb begin
    cp0_we    = advance && slot_w[DEPTH-1].valid;
    cp0_cs    = slot_w[DEPTH-1].valid ? slot_w[DEPTH-1].cs   : '0;
    cp0_sel   = slot_w[DEPTH-1].valid ? slot_w[DEPTH-1].sel  : '0;
    cp0_wdata = slot_w[DEPTH-1].valid ? slot_w[DEPTH-1].data : '0;
  end

endmodule

// File: doc/cp0_fwd_tracker.md
# cp0_fwd_tracker

Parametrised CP0 hazard tracker for the MIPS pipeline. It replaces the per-stage CP0 compare logic with an internal shift-register scoreboard of in-flight `mtc0` writes. It forwards the youngest matching write to `mfc0`/`eret` in ID and stalls ID when the matching write's data is not yet usable. It also drives the CP0 register-file write port when the oldest entry retires.

## Interface
Parameters:
- `DEPTH`, default 3: tracked stages after ID (slot 0 = EX … slot DEPTH-1 = WB).
- `READY_STAGE`, default 0: lowest slot index whose data may be forwarded; a hit in a lower slot stalls ID.
- `DATA_W`, default 32: CP0 data width.
- `CS_W`, default 5: CP0 register-number width.
- `SEL_W`, default 3: CP0 select width.

Ports:
- `clk`  in  1: clock. One clock; all state on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `advance`  in  1: pipeline moves this cycle (0 = global hold).
- `flush`  in  1: kill all speculative entries (slots 0..DEPTH-2).
- `id_valid`  in  1: ID holds a real instruction.
- `id_cp0op`  in  3: 3'b001 mfc0, 3'b010 mtc0, 3'b100 eret; other values = no CP0 op.
- `id_cs`  in  CS_W: CP0 register number.
- `id_sel`  in  SEL_W: CP0 select.
- `id_wdata`  in  DATA_W: mtc0 source data (already GPR-forwarded).
- `fwd_hit`  out  1: forward-data valid.
- `fwd_slot`  out  $clog2(DEPTH)+1: 0 = none, k = slot k-1 supplied the data.
- `fwd_data`  out  DATA_W: forwarded value.
- `stall`  out  1: hold ID/IF this cycle.
- `cp0_we`  out  1: CP0 register-file write enable.
- `cp0_cs`  out  CS_W: write register number.
- `cp0_sel`  out  SEL_W: write select.
- `cp0_wdata`  out  DATA_W: write data.

## Operation
- Each slot holds {valid, cs, sel, data}. Reset and flush clear the valid bits; payload fields are don't-care when valid is 0.
- Read key in ID:
  - mfc0 uses (`id_cs`, `id_sel`).
  - eret uses fixed (14, 0) (EPC) and ignores `id_cs`/`id_sel`.
  - No lookup when `id_valid`=0 or the op is neither mfc0 nor eret.
- Match: slot valid and cs/sel equal. The lowest-indexed (youngest) matching slot wins.
- Winner index < READY_STAGE: `stall`=1, `fwd_hit`=0, `fwd_slot`=0.
- Otherwise: `stall`=0, `fwd_hit`=1, `fwd_slot`=winner+1, `fwd_data`=slot data.
- No match: `fwd_hit`=0, `fwd_slot`=0, `fwd_data`=0.
- Shift on `advance`=1:
  - Slot i+1 takes slot i.
  - Slot 0 takes the ID instruction if it is a valid mtc0 and `stall`=0; otherwise slot 0 takes a bubble.
- `advance`=0: all slots hold. `stall` is still computed.
- Commit: `cp0_we` = `advance` & slot[DEPTH-1].valid. `cp0_cs`/`cp0_sel`/`cp0_wdata` show slot[DEPTH-1] whenever it is valid, else 0.
- `flush` with `advance`:
  - Slot DEPTH-1 still commits; it is past the commit point and is never flushed.
  - Slots 1..DEPTH-1 receive bubbles.
  - Slot 0 receives a bubble.
  - `flush` overrides insertion.
- `flush` without `advance`: slots 0..DEPTH-2 cleared, slot DEPTH-1 kept.
- mtc0 in ID never matches itself. An mtc0 in ID that is stalled is not inserted.

## Timing
- Lookup outputs (`fwd_*`, `stall`) are combinational from ID inputs and slot state, with zero latency.
- The commit outputs are combinational from slot DEPTH-1 and `advance`.
- Insertion is visible to lookup in the cycle after the inserting edge.
- A write in slot k commits DEPTH-1-k advancing edges later; hold cycles add latency one for one.
- `rst` dominates `flush` and `advance`. In the cycle after `rst` is asserted, all slots are invalid and all outputs are 0.
- Reset in mid-pipeline discards uncommitted writes. No partial commit is produced.
- `stall` is independent of `advance`. The pipeline controller combines them.

## Structure
- Shared package `cp0_pkg`:
  - op constants `CP0OP_MFC0`=3'b001, `CP0OP_MTC0`=3'b010, `CP0OP_ERET`=3'b100;
  - `CP0_EPC_CS`=14, `CP0_EPC_SEL`=0;
  - the slot struct typedef {valid, cs, sel, data}.
- One sub-module, `cp0_prio_match`: a parametrised youngest-first priority encoder over DEPTH match bits. It returns hit and index.
- Slot array is a generate-loop register chain; no memories.

## Test plan
- Default params, reset asserted then released: all outputs 0. mfc0 cs=12 sel=0 gives `fwd_hit`=0, `stall`=0.
- mtc0 cs=12 sel=0 data 0x0000_FF01, advance; next cycle mfc0 12/0: `fwd_hit`=1, `fwd_slot`=1, `fwd_data`=0x0000_FF01. After two more advances, `cp0_we`=1 with cs=12, data 0x0000_FF01.
- Back-to-back mtc0 to 14/0 with 0xA0 then 0xB0; eret in ID: `fwd_data`=0xB0, `fwd_slot`=1 (youngest wins over older 0xA0 in slot 1).
- READY_STAGE=1: mtc0 12/0 then immediate mfc0 12/0 gives `stall`=1 and `fwd_hit`=0. Next advance: `stall`=0, `fwd_slot`=2.
- Slots 0..2 hold mtc0 12/0, 13/0, 14/0; assert flush with advance: only 14/0 commits (`cp0_we`=1). Following cycle: all slots invalid, mfc0 13/0 misses.
- `advance`=0 for 3 cycles with mtc0 in slot 2: `cp0_we` stays 0 and forwarding persists. First advance commits exactly once.
